// File: rtl/mul_iter_pkg.sv
// Shared types for the iterative multiplier: RV32M multiply opcodes and FSM states.
// Sign helpers say which operands an op treats as two's complement.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_a_signed(input mul_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/response bundle between the core and the multiplier.
// The master drives start/op/operands; the slave (multiplier) returns ready/valid/product.
interface mul_iter_if
  import mul_pkg::*;
#(
  parameter int N = 32
);
  logic           start_i;
  mul_op_t        op_i;
  logic [N-1:0]   A_i;
  logic [N-1:0]   B_i;
  logic           ready_o;
  logic           valid_o;
  logic [N-1:0]   result_o;
  logic [2*N-1:0] prod_o;

  modport master (
    output start_i, op_i, A_i, B_i,
    input  ready_o, valid_o, result_o, prod_o
  );

  modport slave (
    input  start_i, op_i, A_i, B_i,
    output ready_o, valid_o, result_o, prod_o
  );
endinterface

// File: rtl/mul_iter_adder.sv
// Ripple-style N-bit adder with carry in/out; combinational, no latency, no backpressure.
module adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         Cin_i,
  output logic [N-1:0] S_o,
  output logic         Cout_o
);
  logic [N:0] w_sum;

  assign w_sum  = {1'b0, A_i} + {1'b0, B_i} + {{N{1'b0}}, Cin_i};
  assign S_o    = w_sum[N-1:0];
  assign Cout_o = w_sum[N];
endmodule

// File: rtl/mul_iter.sv
// Shift-and-add RV32M multiplier, fixed N+1 cycles start->valid; ready_o=0 while busy, start ignored then.
// SIGNED_MUL_EN enables signed MULH/MULHSU via magnitude conversion and a final negate.
module mul_iter
  import mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  mul_iter_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_t         r_state, w_state_nxt;
  mul_op_t        r_op;
  logic [N-1:0]   r_mcand, r_mplier, r_result;
  logic [2*N-1:0] r_acc, r_prod;
  logic [CW-1:0]  r_cnt;

  logic           w_start, w_last, w_co;
  logic [N-1:0]   w_addend, w_sum, w_a_mag, w_b_mag, w_result_fin;
  logic [2*N-1:0] w_acc_nxt, w_prod_fin;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  adder #(.N(N)) u_acc_add (
    .A_i    (r_acc[2*N-1:N]),
    .B_i    (w_addend),
    .Cin_i  (1'b0),
    .S_o    (w_sum),
    .Cout_o (w_co)
  );

  // Carry-out lands in the MSB on the shift, so the accumulator never overflows.
  assign w_acc_nxt = {w_co, w_sum, r_acc[N-1:1]};

`ifdef SIGNED_MUL_EN
  logic           r_neg;
  logic           w_a_neg, w_b_neg, w_unused_co;
  logic [2*N-1:0] w_prod_neg;

  assign w_a_neg = op_a_signed(bus.op_i) & bus.A_i[N-1];
  assign w_b_neg = op_b_signed(bus.op_i) & bus.B_i[N-1];
  assign w_a_mag = w_a_neg ? ((~bus.A_i) + ONE_N) : bus.A_i;
  assign w_b_mag = w_b_neg ? ((~bus.B_i) + ONE_N) : bus.B_i;

  adder #(.N(2*N)) u_neg_add (
    .A_i    (~w_acc_nxt),
    .B_i    ('0),
    .Cin_i  (1'b1),
    .S_o    (w_prod_neg),
    .Cout_o (w_unused_co)
  );

  assign w_prod_fin = r_neg ? w_prod_neg : w_acc_nxt;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= w_a_neg ^ w_b_neg;
    end
  end
`else
  assign w_a_mag    = bus.A_i;
  assign w_b_mag    = bus.B_i;
  assign w_prod_fin = w_acc_nxt;
`endif

  assign w_result_fin = (r_op == MUL) ? w_prod_fin[N-1:0] : w_prod_fin[2*N-1:N];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == CW'(N-1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= IDLE;
      r_op     <= MUL;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_mcand  <= w_a_mag;
        r_mplier <= w_b_mag;
        r_op     <= bus.op_i;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_prod   <= w_prod_fin;
          r_result <= w_result_fin;
        end
      end
    end
  end

  assign bus.ready_o  = (r_state == IDLE);
  assign bus.valid_o  = (r_state == DONE);
  assign bus.result_o = r_result;
  assign bus.prod_o   = r_prod;
endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter (N=32): vector table, random ops against an arithmetic model, busy/reset corner cases.
module tb_mul_iter;
  import mul_pkg::*;

  localparam int LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_iter_if #(.N(32)) bus ();

  mul_iter #(.N(32)) dut (
    .clk_i    (clk),
    .resetn_i (rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    mul_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic [31:0] res;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = {32'd0, a};
    be = {32'd0, b};
`ifdef SIGNED_MUL_EN
    if (op == MULH || op == MULHSU) ae = {{32{a[31]}}, a};
    if (op == MULH) be = {{32{b[31]}}, b};
`endif
    return ae * be;
  endfunction

  function automatic logic [31:0] model_res(input mul_op_t op, input logic [63:0] p);
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Issues one op, waits for valid (bounded), then checks the pulse ends and ready returns.
  task automatic do_op(input string name, input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p, output logic [31:0] r);
    int lat;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.A_i     = a;
    bus.B_i     = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    p = bus.prod_o;
    r = bus.result_o;
    @(posedge clk);
    #1;
    chk({name, "_pulse_end"}, {63'd0, bus.valid_o}, 64'd0);
    chk({name, "_ready_back"}, {63'd0, bus.ready_o}, 64'd1);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] r;
    int          pulses;
    int          vlat;

    vt[0] = '{MUL,    32'h12345678, 32'h00000010, 64'h0000000123456780, 32'h23456780};
    vt[1] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
`ifdef SIGNED_MUL_EN
    vt[2] = '{MULH,   32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, 32'hFFFFFFFF};
    vt[3] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF};
`else
    vt[2] = '{MULH,   32'hFFFFFFFE, 32'h00000003, 64'h00000002FFFFFFFA, 32'h00000002};
    vt[3] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
`endif
    vt[4] = '{MUL,    32'h00000000, 32'h00000000, 64'h0000000000000000, 32'h00000000};
    vt[5] = '{MULH,   32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000};

    bus.start_i = 1'b0;
    bus.op_i    = MUL;
    bus.A_i     = '0;
    bus.B_i     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready",  {63'd0, bus.ready_o}, 64'd1);
    chk("rst_valid",  {63'd0, bus.valid_o}, 64'd0);
    chk("rst_result", {32'd0, bus.result_o}, 64'd0);
    chk("rst_prod",   bus.prod_o, 64'd0);

    // Consecutive entries start on the cycle ready returns, so this also covers back-to-back issue.
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, p, r);
      chk($sformatf("vec%0d_prod", i), p, vt[i].prod);
      chk($sformatf("vec%0d_res", i), {32'd0, r}, {32'd0, vt[i].res});
    end

    for (int i = 0; i < 25; i++) begin
      mul_op_t     op;
      logic [31:0] a, b;
      op = mul_op_t'(2'($urandom_range(3)));
      a  = (i % 5 == 0) ? 32'h80000000 : 32'($urandom);
      b  = (i % 7 == 0) ? 32'hFFFFFFFF : 32'($urandom);
      do_op($sformatf("rnd%0d", i), op, a, b, p, r);
      chk($sformatf("rnd%0d_prod", i), p, model_prod(op, a, b));
      chk($sformatf("rnd%0d_res", i), {32'd0, r}, {32'd0, model_res(op, model_prod(op, a, b))});
    end

    // Start while busy must be ignored and leave the latched operands alone.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = MUL;
    bus.A_i     = 32'd3;
    bus.B_i     = 32'd5;
    pulses = 0;
    vlat   = 0;
    r      = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 || i == 11) bus.start_i = 1'b0;
      if (i == 10) begin
        bus.start_i = 1'b1;
        bus.A_i     = 32'd7;
        bus.B_i     = 32'd7;
      end
      if (bus.valid_o) begin
        pulses++;
        if (vlat == 0) vlat = i;
        r = bus.result_o;
      end
    end
    chk("busy_pulses", 64'(pulses), 64'd1);
    chk("busy_latency", 64'(vlat), 64'(LAT));
    chk("busy_result", {32'd0, r}, 64'h0000000F);

    // Reset mid-operation aborts immediately and never pulses valid.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.A_i     = 32'h0000FFFF;
    bus.B_i     = 32'h0000FFFF;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_ready", {63'd0, bus.ready_o}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("abort_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("abort_prod",  bus.prod_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);

    do_op("post_rst", MULHU, 32'h00010000, 32'h00010000, p, r);
    chk("post_rst_prod", p, 64'h0000000100000000);
    chk("post_rst_res", {32'd0, r}, 64'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
